// File: rtl/orbit_pixel_plotter.sv
// orbit_pixel_plotter
// Maps signed (X, Y) orbit positions in metres to screen pixels and draws them
// into a VGA frame buffer through a single write port. It keeps a trail of the
// last TRAIL_LEN lit pixels and erases the oldest one once the trail is full.
// The whole frame is cleared after reset and whenever a clear is requested.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   clear_req     one-cycle pulse requesting a full-screen clear
//   sample_valid  sample present on sample_x / sample_y
//   sample_ready  block can accept a sample
//   sample_x/y    signed position, metres
//   wr_en         frame-buffer write request (address/data held until wr_ready)
//   wr_addr       pixel address, row*H_RES+col
//   wr_data       pixel colour
//   wr_ready      frame buffer accepts the write
//   busy          high whenever the FSM is not idle
//   plot_count    pixels drawn, saturating
//   drop_count    off-screen samples, saturating
module orbit_pixel_plotter #(
    parameter int         H_RES     = 320,
    parameter int         V_RES     = 240,
    parameter int         ADDR_W    = 17,
    parameter int         SHIFT     = 16,
    parameter int         TRAIL_LEN = 64,
    parameter logic [7:0] FG_COLOR  = 8'hFF,
    parameter logic [7:0] BG_COLOR  = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic signed [31:0]       sample_x,
    input  logic signed [31:0]       sample_y,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic [15:0]              plot_count,
    output logic [15:0]              drop_count
);

    localparam int PTR_W = (TRAIL_LEN > 1) ? $clog2(TRAIL_LEN) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  TRAIL_FULL = CNT_W'(TRAIL_LEN);
    localparam logic signed [33:0] H_HALF    = 34'(H_RES / 2);
    localparam logic signed [33:0] V_HALF    = 34'(V_RES / 2);
    localparam logic signed [33:0] H_LIM     = 34'(H_RES);
    localparam logic signed [33:0] V_LIM     = 34'(V_RES);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAP, S_ERASE, S_DRAW} state_t;

    state_t              state_reg, state_next;
    logic signed [31:0]  x_reg, x_next, y_reg, y_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [7:0]          wr_data_reg, wr_data_next;
    logic [ADDR_W-1:0]   clear_idx_reg, clear_idx_next;
    logic                clear_pending_reg, clear_pending_next;
    logic [15:0]         plot_cnt_reg, plot_cnt_next;
    logic [15:0]         drop_cnt_reg, drop_cnt_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]    trail_cnt_reg, trail_cnt_next;
    logic [ADDR_W-1:0]   last_addr_reg, last_addr_next;
    logic [ADDR_W-1:0]   new_addr_reg, new_addr_next;
    logic                push_en;

    logic [ADDR_W-1:0]   trail_mem [TRAIL_LEN];

    // Pixel mapping at 34-bit signed width so the shift and offset cannot wrap.
    logic signed [33:0]  x_ext, y_ext, col, row;
    logic                on_screen;
    logic [ADDR_W-1:0]   map_addr;

    assign x_ext     = {{2{x_reg[31]}}, x_reg};
    assign y_ext     = {{2{y_reg[31]}}, y_reg};
    assign col       = (x_ext >>> SHIFT) + H_HALF;
    assign row       = V_HALF - (y_ext >>> SHIFT);
    assign on_screen = !col[33] && (col < H_LIM) && !row[33] && (row < V_LIM);
    assign map_addr  = row[ADDR_W-1:0] * ADDR_W'(H_RES) + col[ADDR_W-1:0];

    logic accept, wr_done;
    assign accept  = sample_valid && sample_ready;
    assign wr_done = wr_en_reg && wr_ready;

    // State register (and the registered datapath it steers)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= S_CLEAR;
            x_reg             <= '0;
            y_reg             <= '0;
            wr_en_reg         <= 1'b0;
            wr_addr_reg       <= '0;
            wr_data_reg       <= BG_COLOR;
            clear_idx_reg     <= '0;
            clear_pending_reg <= 1'b0;
            plot_cnt_reg      <= '0;
            drop_cnt_reg      <= '0;
            rd_ptr_reg        <= '0;
            wr_ptr_reg        <= '0;
            trail_cnt_reg     <= '0;
            last_addr_reg     <= '0;
            new_addr_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            x_reg             <= x_next;
            y_reg             <= y_next;
            wr_en_reg         <= wr_en_next;
            wr_addr_reg       <= wr_addr_next;
            wr_data_reg       <= wr_data_next;
            clear_idx_reg     <= clear_idx_next;
            clear_pending_reg <= clear_pending_next;
            plot_cnt_reg      <= plot_cnt_next;
            drop_cnt_reg      <= drop_cnt_next;
            rd_ptr_reg        <= rd_ptr_next;
            wr_ptr_reg        <= wr_ptr_next;
            trail_cnt_reg     <= trail_cnt_next;
            last_addr_reg     <= last_addr_next;
            new_addr_reg      <= new_addr_next;
        end
    end

    // Trail storage has no reset; occupancy is tracked by trail_cnt_reg.
    always_ff @(posedge clk) begin
        if (push_en) begin
            trail_mem[wr_ptr_reg] <= wr_addr_reg;
        end
    end

    // Next-state logic
    always_comb begin
        state_next         = state_reg;
        x_next             = x_reg;
        y_next             = y_reg;
        wr_en_next         = wr_en_reg;
        wr_addr_next       = wr_addr_reg;
        wr_data_next       = wr_data_reg;
        clear_idx_next     = clear_idx_reg;
        clear_pending_next = clear_pending_reg;
        plot_cnt_next      = plot_cnt_reg;
        drop_cnt_next      = drop_cnt_reg;
        rd_ptr_next        = rd_ptr_reg;
        wr_ptr_next        = wr_ptr_reg;
        trail_cnt_next     = trail_cnt_reg;
        last_addr_next     = last_addr_reg;
        new_addr_next      = new_addr_reg;
        push_en            = 1'b0;

        // A clear request is remembered until the current work is finished.
        if (clear_req && state_reg != S_CLEAR) begin
            clear_pending_next = 1'b1;
        end

        case (state_reg)
            S_CLEAR: begin
                if (!wr_en_reg) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = clear_idx_reg;
                    wr_data_next = BG_COLOR;
                end else if (wr_done) begin
                    if (clear_idx_reg == LAST_PIX) begin
                        wr_en_next         = 1'b0;
                        clear_pending_next = 1'b0;
                        rd_ptr_next        = '0;
                        wr_ptr_next        = '0;
                        trail_cnt_next     = '0;
                        state_next         = S_IDLE;
                    end else begin
                        clear_idx_next = clear_idx_reg + ADDR_W'(1);
                        wr_addr_next   = clear_idx_reg + ADDR_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (clear_pending_reg) begin
                    clear_idx_next = '0;
                    state_next     = S_CLEAR;
                end else if (accept) begin
                    x_next     = sample_x;
                    y_next     = sample_y;
                    state_next = S_MAP;
                end
            end
            S_MAP: begin
                if (!on_screen) begin
                    if (drop_cnt_reg != 16'hFFFF) drop_cnt_next = drop_cnt_reg + 16'd1;
                    state_next = S_IDLE;
                end else if (trail_cnt_reg != '0 && map_addr == last_addr_reg) begin
                    state_next = S_IDLE;
                end else if (trail_cnt_reg == TRAIL_FULL) begin
                    wr_en_next    = 1'b1;
                    wr_addr_next  = trail_mem[rd_ptr_reg];
                    wr_data_next  = BG_COLOR;
                    new_addr_next = map_addr;
                    state_next    = S_ERASE;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = map_addr;
                    wr_data_next = FG_COLOR;
                    state_next   = S_DRAW;
                end
            end
            S_ERASE: begin
                if (wr_done) begin
                    rd_ptr_next    = rd_ptr_reg + PTR_W'(1);
                    trail_cnt_next = trail_cnt_reg - CNT_W'(1);
                    wr_addr_next   = new_addr_reg;
                    wr_data_next   = FG_COLOR;
                    state_next     = S_DRAW;
                end
            end
            S_DRAW: begin
                if (wr_done) begin
                    push_en        = 1'b1;
                    wr_ptr_next    = wr_ptr_reg + PTR_W'(1);
                    trail_cnt_next = trail_cnt_reg + CNT_W'(1);
                    last_addr_next = wr_addr_reg;
                    if (plot_cnt_reg != 16'hFFFF) plot_cnt_next = plot_cnt_reg + 16'd1;
                    wr_en_next     = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_CLEAR;
        endcase
    end

    // Outputs
    always_comb begin
        sample_ready = (state_reg == S_IDLE) && !clear_pending_reg;
        busy         = (state_reg != S_IDLE);
        wr_en        = wr_en_reg;
        wr_addr      = wr_addr_reg;
        wr_data      = wr_data_reg;
        plot_count   = plot_cnt_reg;
        drop_count   = drop_cnt_reg;
    end

endmodule

// File: tb/tb_orbit_pixel_plotter.sv
// Directed bench for orbit_pixel_plotter with a small 8x4 screen and a
// two-entry trail. Expected frame-buffer writes are queued when stimulus is
// driven and matched against each completed write by a monitor.
module tb_orbit_pixel_plotter;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 17;
    localparam int SH = 4;
    localparam int TL = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clear_req = 1'b0;
    logic                sample_valid = 1'b0;
    logic                sample_ready;
    logic signed [31:0]  sample_x = '0;
    logic signed [31:0]  sample_y = '0;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [7:0]          wr_data;
    logic                wr_ready = 1'b1;
    logic                busy;
    logic [15:0]         plot_count;
    logic [15:0]         drop_count;

    orbit_pixel_plotter #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .SHIFT(SH), .TRAIL_LEN(TL),
        .FG_COLOR(8'hFF), .BG_COLOR(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_x(sample_x), .sample_y(sample_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .plot_count(plot_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  total  = 0;
    int  bad    = 0;
    int  wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_clear();
        for (int i = 0; i < H * V; i++) push_wr(i, 8'h00);
    endtask

    // Counts negedges from the MAP cycle (n=1) until sample_ready is seen.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        forever begin
            n++;
            @(negedge clk);
            if (sample_ready) break;
            if (n > 200) begin
                chk(tag, 32'(sample_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic send(input logic signed [31:0] x, input logic signed [31:0] y, input logic clr);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_x     = x;
        sample_y     = y;
        clear_req    = clr;
        @(negedge clk);
        chk("accept_ready", 32'(sample_ready), 32'd1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        clear_req    = 1'b0;
    endtask

    // Scoreboard side: every completed write must match the queue head.
    always @(negedge clk) begin
        if (rst && wr_en && wr_ready) begin
            wr_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed addr=%0d data=%0h expected none", wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        int n;
        int w0;
        logic seen_ready;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_plot", 32'(plot_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // 1: start-up clear of all 32 pixels
        expect_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ready("startup_clear_timeout", n);
        chk("startup_writes", 32'(wr_cnt), 32'd32);
        chk("startup_q_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("txn clear: writes=%0d", wr_cnt);

        // 2: two on-screen samples
        push_wr(20, 8'hFF);
        send(32'sd0, 32'sd0, 1'b0);
        wait_ready("s00_timeout", n);
        chk("s00_latency", 32'(n), 32'd3);
        chk("s00_plot", 32'(plot_count), 32'd1);
        $display("txn (0,0): latency=%0d plot=%0d", n, plot_count);

        push_wr(11, 8'hFF);
        send(-32'sd16, 32'sd16, 1'b0);
        wait_ready("s11_timeout", n);
        chk("s11_latency", 32'(n), 32'd3);
        chk("s11_plot", 32'(plot_count), 32'd2);
        $display("txn (-16,16): latency=%0d plot=%0d", n, plot_count);

        // 3: off-screen drop, then duplicate of the last pixel
        send(32'sd64, 32'sd0, 1'b0);
        wait_ready("drop_timeout", n);
        chk("drop_latency", 32'(n), 32'd2);
        chk("drop_count", 32'(drop_count), 32'd1);
        chk("drop_plot", 32'(plot_count), 32'd2);
        $display("txn (64,0): latency=%0d drop=%0d", n, drop_count);

        send(-32'sd16, 32'sd16, 1'b0);
        wait_ready("dup_timeout", n);
        chk("dup_latency", 32'(n), 32'd2);
        chk("dup_plot", 32'(plot_count), 32'd2);
        chk("dup_drop", 32'(drop_count), 32'd1);
        $display("txn dup (-16,16): latency=%0d plot=%0d", n, plot_count);

        // 4: trail full -> erase oldest then draw, back to back
        push_wr(20, 8'h00);
        push_wr(21, 8'hFF);
        w0 = wr_cnt;
        send(32'sd16, 32'sd0, 1'b0);
        wait_ready("erase_timeout", n);
        chk("erase_latency", 32'(n), 32'd4);
        chk("erase_writes", 32'(wr_cnt - w0), 32'd2);
        chk("erase_plot", 32'(plot_count), 32'd3);
        $display("txn (16,0): latency=%0d plot=%0d", n, plot_count);

        // 5: back-pressure during DRAW (erase 11, then draw 12)
        push_wr(11, 8'h00);
        push_wr(12, 8'hFF);
        w0 = wr_cnt;
        send(32'sd0, 32'sd16, 1'b0);
        @(negedge clk);                // MAP
        @(posedge clk); #1;            // ERASE, completes at the end of this cycle
        @(posedge clk); #1;            // DRAW
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wr_en", 32'(wr_en), 32'd1);
            chk("stall_wr_addr", 32'(wr_addr), 32'd12);
            chk("stall_wr_data", 32'(wr_data), 32'hFF);
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        @(negedge clk);
        chk("stall_wr_en4", 32'(wr_en), 32'd1);
        chk("stall_wr_addr4", 32'(wr_addr), 32'd12);
        wait_ready("stall_timeout", n);
        chk("stall_writes", 32'(wr_cnt - w0), 32'd2);
        chk("stall_plot", 32'(plot_count), 32'd4);
        $display("txn (0,16) stalled: writes=%0d plot=%0d", wr_cnt - w0, plot_count);

        // 6: clear_req with acceptance, then reset mid-clear
        push_wr(21, 8'h00);
        push_wr(13, 8'hFF);
        expect_clear();
        w0 = wr_cnt;
        send(32'sd16, 32'sd16, 1'b1);
        seen_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen_ready = seen_ready | sample_ready;
            if (wr_cnt - w0 >= 12) break;
        end
        chk("clr_progress", 32'(wr_cnt - w0 >= 12), 32'd1);
        chk("clr_ready_low", 32'(seen_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_plot", 32'(plot_count), 32'd5);
        $display("txn (16,16)+clear: writes=%0d plot=%0d", wr_cnt - w0, plot_count);

        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_plot", 32'(plot_count), 32'd0);
        repeat (2) @(negedge clk);
        expect_clear();
        w0 = wr_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ready("reclear_timeout", n);
        chk("reclear_writes", 32'(wr_cnt - w0), 32'd32);
        chk("reclear_q_empty", 32'(exp_q.size()), 32'd0);
        chk("reclear_drop", 32'(drop_count), 32'd0);
        $display("txn reset-clear: writes=%0d", wr_cnt - w0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
